arm_imm_encoder: RTL and testbench
==================================

// Module: arm_imm_encoder
// PURPOSE
//  Sequential encoder for ARM data-processing immediates, the inverse of the shifter/sign-extender immediate decode.
//  Given a 32-bit constant, searches for {rot[3:0], imm8} such that value == imm8 ROR (2*rot).
//  If enabled and the direct search fails, retries on ~value, which the caller emits as an MVN/BIC encoding.
//  Used by the instruction loader/test-program builder and by the verification harness.
// PARAMETERS
//  ALLOW_INV_DEFAULT  1'b1  reset value of the internal inverse-enable latch (overridden by try_inv at start)
// PORTS
//  clk         in   1   system clock; all state updates on rising edge
//  reset_n     in   1   synchronous active-low reset
//  start       in   1   request; accepted only in IDLE
//  value       in   32  constant to encode; sampled when start is accepted
//  try_inv     in   1   allow the ~value retry; sampled with start
//  cin         in   1   current C flag; sampled with start; used for carry_out when rot==0
//  busy        out  1   high in SEARCH and DONE
//  done        out  1   one-cycle pulse: result valid
//  found       out  1   encoding exists; held until next accepted start
//  imm12       out  12  {rot, imm8}; 12'h000 when found==0
//  inverted    out  1   encoding is for ~value
//  carry_out   out  1   shifter carry the decoder produces: rot==0 -> sampled cin, else decoded[31]
// BEHAVIOUR
//  Reset (reset_n==0 at clk edge): state=IDLE; busy, done, found, inverted, carry_out = 0; imm12 = 0.
//   Reset has priority over everything, including mid-search; a partial search is discarded.
//  FSM:
//   IDLE   -> SEARCH on start: latch value/try_inv/cin; rot_cnt=0; pass=DIRECT; clear found/imm12/inverted.
//   SEARCH -> one candidate per cycle: t = (pass==INV ? ~v : v) ROL (2*rot_cnt);
//             hit when t[31:8]==0 -> latch imm8=t[7:0], rot=rot_cnt, inverted=(pass==INV), found=1; go to DONE.
//             miss and rot_cnt<15 -> rot_cnt+1.
//             miss, rot_cnt==15, pass==DIRECT, try_inv -> pass=INV, rot_cnt=0.
//             miss at the final candidate -> found=0; go to DONE.
//   DONE   -> done=1 for exactly this cycle; go to IDLE. Outputs held until next accepted start.
//  First hit wins: DIRECT before INV; smallest rot first; result is deterministic.
//  Latency: start accepted at edge N; candidate k (0..31 across both passes) tested in cycle N+1+k;
//   done in cycle N+2+k. Worst case 33 cycles after start (inverse enabled, no encoding); 17 without inverse.
//  carry_out = (rot==0) ? cin_latched : decoded[31], where decoded = imm8 ROR 2*rot, uninverted.
//  start while busy (including in DONE) is ignored; no queueing. start in the same cycle as reset_n==0 is ignored.
//  value/try_inv/cin changes after acceptance have no effect.
//  ROL/ROR amounts are 0..30, even only; rotation wraps mod 32.
// TESTING
//  1 value=0x00000000 -> done 2 cycles after start; found=1, imm12=0x000, inverted=0, carry_out=cin.
//  2 value=0x0003FC00 -> hit at rot=11; done 13 cycles after start; imm12=0xBFF; carry_out=0.
//  3 value=0xF000000F, cin=0 -> imm12=0x2FF, found=1, carry_out=1; value=0x00000104 -> imm12=0xF41.
//  4 value=0xFFFFFFFF, try_inv=1 -> found=1, inverted=1, imm12=0x000; with try_inv=0 -> found=0 at 17 cycles.
//  5 value=0x000001FE, try_inv=1 -> found=0, imm12=0, done exactly 33 cycles after start.
//  6 pull reset_n low mid-search, then apply start pulses while busy -> all outputs 0 and IDLE after reset;
//    busy-time starts do not perturb the result or its timing.

Source files
------------

// File: rtl/arm_imm_encoder.sv
// Sequential ARM data-processing immediate encoder: finds {rot, imm8} with value == imm8 ROR 2*rot,
// optionally retrying on ~value (MVN/BIC form). One candidate rotation is tested per clock.
module arm_imm_encoder #(
    parameter logic ALLOW_INV_DEFAULT = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] value,
    input  logic        try_inv,
    input  logic        cin,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [11:0] imm12,
    output logic        inverted,
    output logic        carry_out
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic PASS_DIRECT = 1'b0;
    localparam logic PASS_INV    = 1'b1;

    logic [1:0]  state_q,     state_d;
    logic [31:0] value_q,     value_d;
    logic        allow_inv_q, allow_inv_d;
    logic        cin_q,       cin_d;
    logic [3:0]  rot_cnt_q,   rot_cnt_d;
    logic        pass_q,      pass_d;
    logic        found_q,     found_d;
    logic [11:0] imm12_q,     imm12_d;
    logic        inverted_q,  inverted_d;
    logic        carry_q,     carry_d;

    logic [31:0] cand_src;
    logic [5:0]  cand_sh;
    logic [31:0] cand_rot;
    logic        cand_hit;

    // Rotating the source left by 2*rot undoes the decoder's ROR; a hit leaves only 8 live bits.
    always_comb begin
        cand_src = (pass_q == PASS_INV) ? ~value_q : value_q;
        cand_sh  = {1'b0, rot_cnt_q, 1'b0};
        cand_rot = (cand_src << cand_sh) | (cand_src >> (6'd32 - cand_sh));
        cand_hit = (cand_rot[31:8] == 24'd0);
    end

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        allow_inv_d = allow_inv_q;
        cin_d       = cin_q;
        rot_cnt_d   = rot_cnt_q;
        pass_d      = pass_q;
        found_d     = found_q;
        imm12_d     = imm12_q;
        inverted_d  = inverted_q;
        carry_d     = carry_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    value_d     = value;
                    allow_inv_d = try_inv;
                    cin_d       = cin;
                    rot_cnt_d   = 4'd0;
                    pass_d      = PASS_DIRECT;
                    found_d     = 1'b0;
                    imm12_d     = 12'h000;
                    inverted_d  = 1'b0;
                    carry_d     = 1'b0;
                    state_d     = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (cand_hit) begin
                    found_d    = 1'b1;
                    imm12_d    = {rot_cnt_q, cand_rot[7:0]};
                    inverted_d = (pass_q == PASS_INV);
                    // The decoded immediate equals the searched source, so its MSB is the shifter carry.
                    carry_d    = (rot_cnt_q == 4'd0) ? cin_q : cand_src[31];
                    state_d    = S_DONE;
                end else if (rot_cnt_q != 4'd15) begin
                    rot_cnt_d = rot_cnt_q + 4'd1;
                end else if ((pass_q == PASS_DIRECT) && allow_inv_q) begin
                    pass_d    = PASS_INV;
                    rot_cnt_d = 4'd0;
                end else begin
                    found_d = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            value_q     <= 32'd0;
            allow_inv_q <= ALLOW_INV_DEFAULT;
            cin_q       <= 1'b0;
            rot_cnt_q   <= 4'd0;
            pass_q      <= PASS_DIRECT;
            found_q     <= 1'b0;
            imm12_q     <= 12'h000;
            inverted_q  <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            allow_inv_q <= allow_inv_d;
            cin_q       <= cin_d;
            rot_cnt_q   <= rot_cnt_d;
            pass_q      <= pass_d;
            found_q     <= found_d;
            imm12_q     <= imm12_d;
            inverted_q  <= inverted_d;
            carry_q     <= carry_d;
        end
    end

    always_comb begin
        busy      = (state_q == S_SEARCH) || (state_q == S_DONE);
        done      = (state_q == S_DONE);
        found     = found_q;
        imm12     = imm12_q;
        inverted  = inverted_q;
        carry_out = carry_q;
    end

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Scoreboard bench for arm_imm_encoder: stimulus pushes model predictions, a monitor checks each done pulse.
module tb_arm_imm_encoder;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] value;
    logic        try_inv;
    logic        cin;
    logic        busy;
    logic        done;
    logic        found;
    logic [11:0] imm12;
    logic        inverted;
    logic        carry_out;

    typedef struct {
        logic        found;
        logic [11:0] imm12;
        logic        inv;
        logic        carry;
        int          lat;
        int          accept_edge;
        logic [31:0] value;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    arm_imm_encoder #(.ALLOW_INV_DEFAULT(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .value(value),
        .try_inv(try_inv), .cin(cin), .busy(busy), .done(done), .found(found),
        .imm12(imm12), .inverted(inverted), .carry_out(carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        logic [31:0] r;
        r = x;
        for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
        return r;
    endfunction

    // Reference: try every (pass, rot) in priority order and accept when the decoded immediate reproduces the source.
    function automatic exp_t model(input logic [31:0] v, input logic ti, input logic c);
        exp_t        e;
        logic [31:0] src;
        logic [31:0] lo;
        logic [31:0] dec;
        e.found = 1'b0; e.imm12 = 12'h000; e.inv = 1'b0; e.carry = 1'b0;
        e.lat = ti ? 33 : 17; e.accept_edge = 0; e.value = v;
        for (int p = 0; p < 2; p++) begin
            if (p == 1 && !ti) break;
            src = (p == 1) ? ~v : v;
            for (int r = 0; r < 16; r++) begin
                lo  = ror32(src, (32 - 2 * r) % 32) & 32'h0000_00FF;
                dec = ror32(lo, 2 * r);
                if (dec == src) begin
                    e.found = 1'b1;
                    e.imm12 = {r[3:0], lo[7:0]};
                    e.inv   = (p == 1);
                    e.carry = (r == 0) ? c : dec[31];
                    e.lat   = p * 16 + r + 2;
                    return e;
                end
            end
        end
        return e;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_done: got done=1 expected none pending");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_output("found",    {31'd0, found},    {31'd0, e.found});
                check_output("imm12",    {20'd0, imm12},    {20'd0, e.imm12});
                check_output("inverted", {31'd0, inverted}, {31'd0, e.inv});
                if (e.found) check_output("carry_out", {31'd0, carry_out}, {31'd0, e.carry});
                check_output("latency_edges", cyc - e.accept_edge, e.lat - 1);
                check_output("busy_in_done", {31'd0, busy}, 32'd1);
            end
        end
    end

    // Issues one accepted request, then hammers ignored starts and input changes until its result is consumed.
    task automatic apply_stimulus(input logic [31:0] v, input logic ti, input logic c);
        exp_t e;
        int   n;
        @(negedge clk);
        value = v; try_inv = ti; cin = c; start = 1'b1;
        e = model(v, ti, c);
        e.accept_edge = cyc + 1;
        sb_q.push_back(e);
        n = 0;
        forever begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                start = 1'b0;
                break;
            end
            n++;
            if (n > 40) begin
                tests++;
                fails++;
                $display("[TB] FAIL done_timeout: got no done after %0d cycles expected at most 33", n);
                finish_run();
            end
            start   = 1'($urandom_range(0, 1));
            value   = $urandom;
            try_inv = 1'($urandom_range(0, 1));
            cin     = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_busy"},     {31'd0, busy},      32'd0);
        check_output({tag, "_done"},     {31'd0, done},      32'd0);
        check_output({tag, "_found"},    {31'd0, found},     32'd0);
        check_output({tag, "_imm12"},    {20'd0, imm12},     32'd0);
        check_output({tag, "_inverted"}, {31'd0, inverted},  32'd0);
        check_output({tag, "_carry"},    {31'd0, carry_out}, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] r8;
        int          kind;
        int          rot;
        reset_n = 1'b0; start = 1'b0; value = 32'd0; try_inv = 1'b0; cin = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        apply_stimulus(32'h0000_0000, 1'b1, 1'b1);
        apply_stimulus(32'h0003_FC00, 1'b0, 1'b1);
        apply_stimulus(32'hF000_000F, 1'b0, 1'b0);
        apply_stimulus(32'h0000_0104, 1'b1, 1'b0);
        apply_stimulus(32'hFFFF_FFFF, 1'b1, 1'b1);
        apply_stimulus(32'hFFFF_FFFF, 1'b0, 1'b1);
        apply_stimulus(32'h0000_01FE, 1'b1, 1'b0);
        apply_stimulus(32'h8000_0000, 1'b0, 1'b0);

        // Abort a long search with reset, with a start request coinciding with reset.
        @(negedge clk);
        value = 32'h0000_01FE; try_inv = 1'b1; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0; start = 1'b1; value = 32'd0;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(negedge clk);
        start = 1'b0; reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check_output("idle_after_reset_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 3);
            rot  = $urandom_range(0, 15);
            r8   = ror32({24'd0, 8'($urandom)}, 2 * rot);
            case (kind)
                0:       v = $urandom;
                1:       v = r8;
                2:       v = ~r8;
                default: v = ror32(32'($urandom_range(0, 1023)), $urandom_range(0, 31));
            endcase
            apply_stimulus(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        finish_run();
    end

    initial begin
        #500000;
        tests++;
        fails++;
        $display("[TB] FAIL global_timeout: got still running expected finished");
        finish_run();
    end

endmodule
